// File: rtl/ps2_scancode_decoder_pkg.sv
// Scan Code Set 2 constants, decoder state encoding and modifier lookup
// shared by the PS/2 scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam logic [7:0] BAT_OK     = 8'hAA;
    localparam logic [7:0] BAT_FAIL   = 8'hFC;
    localparam logic [7:0] ACK        = 8'hFA;
    localparam logic [7:0] RESEND     = 8'hFE;
    localparam logic [7:0] ECHO       = 8'hEE;
    localparam logic [7:0] FAKE_SHIFT = 8'h12;

    localparam logic [7:0] MOD_LSHIFT = 8'h12;
    localparam logic [7:0] MOD_RSHIFT = 8'h59;
    localparam logic [7:0] MOD_CTRL   = 8'h14;
    localparam logic [7:0] MOD_ALT    = 8'h11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    // Element [k] is the byte expected at Pause index k.
    localparam logic [7:0][7:0] PAUSE_SEQ = {
        8'h77, 8'hF0, 8'h14, 8'hF0, 8'hE1, 8'h77, 8'h14, 8'hE1
    };

    // Bit order {ralt, lalt, rctrl, lctrl, rshift, lshift}.
    function automatic logic [5:0] mod_mask(input logic [7:0] code, input logic ext);
        logic [5:0] m;
        m = '0;
        if (code == MOD_LSHIFT && !ext) m[0] = 1'b1;
        if (code == MOD_RSHIFT && !ext) m[1] = 1'b1;
        if (code == MOD_CTRL   && !ext) m[2] = 1'b1;
        if (code == MOD_CTRL   &&  ext) m[3] = 1'b1;
        if (code == MOD_ALT    && !ext) m[4] = 1'b1;
        if (code == MOD_ALT    &&  ext) m[5] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_mod.sv
// Modulo-MOD up counter with synchronous clear; o_tc flags the last count.
module mod #(
    parameter int MOD = 200_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tc
);
    localparam int W = (MOD > 1) ? $clog2(MOD) : 1;

    logic [W-1:0] r_cnt;
    logic         w_tc;

    assign w_tc = (r_cnt == W'(MOD - 1));
    assign o_tc = w_tc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (w_tc)  r_cnt <= '0;
        else            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds Scan Code Set 2 prefix sequences into single key events, tracks
// modifier state, and drops stale partial sequences via a watchdog.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CNT = 200_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_rdy,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_break,
    output logic       o_key_valid,
    output logic [5:0] o_mods,
    output logic       o_bat_ok,
    output logic       o_err
);
    state_t     r_state, w_state_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic       w_emit, w_ext, w_brk, w_err, w_bat, w_tc;
    logic [7:0] w_code;

    logic [7:0] r_key_code;
    logic       r_key_ext, r_key_break, r_key_valid, r_bat_ok, r_err;
    logic [5:0] r_mods;

    mod #(.MOD(TIMEOUT_CNT)) u_wdog (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_rx_rdy || (r_state == ST_IDLE)),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_emit      = 1'b0;
        w_code      = i_rx_data;
        w_ext       = 1'b0;
        w_brk       = 1'b0;
        w_err       = 1'b0;
        w_bat       = 1'b0;
        if (i_rx_rdy) begin
            case (r_state)
                ST_IDLE: begin
                    case (i_rx_data)
                        PFX_EXT:                  w_state_nxt = ST_EXT;
                        PFX_BRK:                  w_state_nxt = ST_BRK;
                        PFX_PAUSE: begin
                            w_state_nxt = ST_PAUSE;
                            w_idx_nxt   = 3'd1;
                        end
                        8'h00, 8'hFF, BAT_FAIL:   w_err = 1'b1;
                        BAT_OK:                   w_bat = 1'b1;
                        ACK, RESEND, ECHO:        ;
                        default:                  w_emit = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    w_state_nxt = ST_IDLE;
                    if (i_rx_data == PFX_BRK)                                  w_state_nxt = ST_EXT_BRK;
                    else if (i_rx_data == FAKE_SHIFT)                          ;
                    else if (i_rx_data == PFX_EXT || i_rx_data == PFX_PAUSE)   w_err = 1'b1;
                    else begin
                        w_emit = 1'b1;
                        w_ext  = 1'b1;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    w_state_nxt = ST_IDLE;
                    if (i_rx_data == PFX_EXT || i_rx_data == PFX_PAUSE || i_rx_data == PFX_BRK)
                        w_err = 1'b1;
                    else if (r_state == ST_EXT_BRK && i_rx_data == FAKE_SHIFT)
                        ;
                    else begin
                        w_emit = 1'b1;
                        w_brk  = 1'b1;
                        w_ext  = (r_state == ST_EXT_BRK);
                    end
                end
                ST_PAUSE: begin
                    if (i_rx_data != PAUSE_SEQ[r_idx]) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                    end else if (r_idx == 3'd7) begin
                        w_emit      = 1'b1;
                        w_ext       = 1'b1;
                        w_code      = 8'h77;
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end else if (r_state != ST_IDLE && w_tc) begin
            // A byte on the timeout cycle takes the branch above instead.
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key_code  <= '0;
            r_key_ext   <= 1'b0;
            r_key_break <= 1'b0;
            r_key_valid <= 1'b0;
            r_mods      <= '0;
            r_bat_ok    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_key_valid <= w_emit;
            r_bat_ok    <= w_bat;
            r_err       <= w_err;
            if (w_emit) begin
                r_key_code  <= w_code;
                r_key_ext   <= w_ext;
                r_key_break <= w_brk;
                r_mods      <= w_brk ? (r_mods & ~mod_mask(w_code, w_ext))
                                     : (r_mods |  mod_mask(w_code, w_ext));
            end
        end
    end

    assign o_key_code  = r_key_code;
    assign o_key_ext   = r_key_ext;
    assign o_key_break = r_key_break;
    assign o_key_valid = r_key_valid;
    assign o_mods      = r_mods;
    assign o_bat_ok    = r_bat_ok;
    assign o_err       = r_err;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed table-driven bench for the PS/2 scan-code decoder plus hand
// sequences for Pause corruption, watchdog and mid-sequence reset.
module tb_ps2_scancode_decoder;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_rdy = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, bat_ok, err;
    logic [5:0] mods;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.TIMEOUT_CNT(T)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_rdy    (rx_rdy),
        .o_key_code  (key_code),
        .o_key_ext   (key_ext),
        .o_key_break (key_break),
        .o_key_valid (key_valid),
        .o_mods      (mods),
        .o_bat_ok    (bat_ok),
        .o_err       (err)
    );

    typedef struct {
        logic       rdy;
        logic [7:0] data;
        logic       v;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [5:0] mods;
        logic       bat;
        logic       err;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rdy, input logic [7:0] data, input logic v,
                       input logic [7:0] code, input logic ext, input logic brk,
                       input logic [5:0] m, input logic bat, input logic e);
        vec_t x;
        x.rdy = rdy; x.data = data; x.v = v; x.code = code; x.ext = ext;
        x.brk = brk; x.mods = m; x.bat = bat; x.err = e;
        vt.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One byte (or idle) cycle; outputs sampled just after the sampling edge.
    task automatic step(input logic rdy, input logic [7:0] data);
        @(negedge clk);
        rx_rdy  = rdy;
        rx_data = data;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
    endtask

    task automatic nb(input logic [7:0] d, input logic [5:0] m);
        add(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, m, 1'b0, 1'b0);
    endtask

    task automatic ev(input logic [7:0] d, input logic ext, input logic brk, input logic [5:0] m);
        add(1'b1, d, 1'b1, d, ext, brk, m, 1'b0, 1'b0);
    endtask

    task automatic er(input logic [7:0] d, input logic [5:0] m);
        add(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, m, 1'b0, 1'b1);
    endtask

    int errs, first_err, vals;

    initial begin
        // Plain make, then E0 F0 75 back-to-back
        ev(8'h1C, 0, 0, 6'h00);
        nb(8'hE0, 6'h00); nb(8'hF0, 6'h00); ev(8'h75, 1, 1, 6'h00);
        // Modifiers
        ev(8'h12, 0, 0, 6'h01);
        nb(8'hF0, 6'h01); ev(8'h12, 0, 1, 6'h00);
        nb(8'hE0, 6'h00); ev(8'h14, 1, 0, 6'h08);
        ev(8'h59, 0, 0, 6'h0A);
        ev(8'h11, 0, 0, 6'h1A);
        nb(8'hE0, 6'h1A); ev(8'h11, 1, 0, 6'h3A);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 6'h3A, 1'b0, 1'b0);
        nb(8'hF0, 6'h3A); ev(8'h14, 0, 1, 6'h3A);
        nb(8'hE0, 6'h3A); nb(8'hF0, 6'h3A); ev(8'h14, 1, 1, 6'h32);
        nb(8'hF0, 6'h32); ev(8'h59, 0, 1, 6'h30);
        nb(8'hF0, 6'h30); ev(8'h11, 0, 1, 6'h20);
        nb(8'hE0, 6'h20); nb(8'hF0, 6'h20); ev(8'h11, 1, 1, 6'h00);
        // Full Pause sequence
        nb(8'hE1, 6'h00); nb(8'h14, 6'h00); nb(8'h77, 6'h00); nb(8'hE1, 6'h00);
        nb(8'hF0, 6'h00); nb(8'h14, 6'h00); nb(8'hF0, 6'h00); ev(8'h77, 1, 0, 6'h00);
        // IDLE specials
        add(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
        er(8'h00, 6'h00); er(8'hFF, 6'h00); er(8'hFC, 6'h00);
        nb(8'hFA, 6'h00); nb(8'hFE, 6'h00); nb(8'hEE, 6'h00);
        // Fake shifts
        nb(8'hE0, 6'h00); nb(8'h12, 6'h00);
        nb(8'hE0, 6'h00); nb(8'hF0, 6'h00); nb(8'h12, 6'h00);
        // Prefix errors
        nb(8'hF0, 6'h00); er(8'hE0, 6'h00);
        nb(8'hE0, 6'h00); er(8'hE1, 6'h00);
        nb(8'hE0, 6'h00); nb(8'hF0, 6'h00); er(8'hF0, 6'h00);
        nb(8'hE1, 6'h00); er(8'hE0, 6'h00);
        ev(8'h1C, 0, 0, 6'h00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", key_valid, 0); chk("rst_code", key_code, 0);
        chk("rst_mods", mods, 0);       chk("rst_err", err, 0);
        chk("rst_bat", bat_ok, 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].rdy, vt[i].data);
            chk($sformatf("v%0d_valid", i), key_valid, vt[i].v);
            chk($sformatf("v%0d_err", i), err, vt[i].err);
            chk($sformatf("v%0d_bat", i), bat_ok, vt[i].bat);
            chk($sformatf("v%0d_mods", i), mods, vt[i].mods);
            if (vt[i].v) begin
                chk($sformatf("v%0d_code", i), key_code, vt[i].code);
                chk($sformatf("v%0d_ext", i), key_ext, vt[i].ext);
                chk($sformatf("v%0d_brk", i), key_break, vt[i].brk);
            end
        end

        // Corrupted Pause: third byte 78
        vals = 0; errs = 0;
        step(1, 8'hE1); vals += key_valid; errs += err;
        step(1, 8'h14); vals += key_valid; errs += err;
        step(1, 8'h78); chk("pc_err", err, 1); vals += key_valid;
        for (int i = 0; i < 3; i++) begin step(0, 8'h00); vals += key_valid; errs += err; end
        chk("pc_noevent", vals, 0);
        chk("pc_noearly_err", errs, 0);

        // Watchdog timeout after E0
        errs = 0; first_err = -1; vals = 0;
        step(1, 8'hE0);
        for (int i = 0; i < T + 4; i++) begin
            step(0, 8'h00);
            if (err) begin errs++; if (first_err < 0) first_err = i; end
            vals += key_valid;
        end
        chk("wd_err_count", errs, 1);
        chk("wd_err_cycle", first_err, T - 1);
        chk("wd_noevent", vals, 0);
        step(1, 8'h1C);
        chk("wd_after_valid", key_valid, 1); chk("wd_after_code", key_code, 8'h1C);
        chk("wd_after_ext", key_ext, 0);

        // Byte arriving on the exact timeout cycle wins
        errs = 0;
        step(1, 8'hE0);
        for (int i = 0; i < T - 1; i++) begin step(0, 8'h00); errs += err; end
        step(1, 8'h1C);
        errs += err;
        chk("edge_valid", key_valid, 1); chk("edge_ext", key_ext, 1);
        chk("edge_code", key_code, 8'h1C);
        for (int i = 0; i < T + 2; i++) begin step(0, 8'h00); errs += err; end
        chk("edge_no_err", errs, 0);

        // Reset in the middle of a break sequence
        step(1, 8'h12);
        chk("pre_rst_mods", mods, 6'h01);
        step(1, 8'hF0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mid_rst_mods", mods, 0); chk("mid_rst_code", key_code, 0);
        @(posedge clk); #1;
        chk("mid_rst_valid", key_valid, 0); chk("mid_rst_err", err, 0);
        chk("mid_rst_bat", bat_ok, 0);
        @(negedge clk) rst_n = 1'b1;
        step(1, 8'h1C);
        chk("post_rst_valid", key_valid, 1); chk("post_rst_brk", key_break, 0);
        chk("post_rst_code", key_code, 8'h1C); chk("post_rst_mods", mods, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Invariant: err and key_valid are mutually exclusive.
    always @(negedge clk) begin
        if (rst_n && err && key_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL err_and_valid: got both 1 expected at most one");
        end
    end
endmodule
